alu_issue_stage: RTL and testbench

//  ID->EX issue register for the MIPS pipeline: decodes a 32-bit instruction into ALU

---
 rtl/alu_issue_stage.sv | 146 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decodes a MIPS instruction into ALU select/shamt/operands and
// registers them with stall, flush and illegal-opcode handling. Optional feature: ILLEGAL_CNT_EN.
module alu_issue_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [3:0]       alu_select,
    output logic [4:0]       alu_shamt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             illegal
`ifdef ILLEGAL_CNT_EN
    ,
    output logic [15:0]      illegal_cnt
`endif
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MULT = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_SRL  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_SRLV = 4'b0110,
        OP_SRAV = 4'b0111,
        OP_SLLV = 4'b1000,
        OP_OR   = 4'b1001
    } alu_op_e;

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] imm_zext;
    logic [WIDTH-1:0] rs_shift;

    // Register-number fields are consumed upstream by the register file.
    logic             unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign imm_sext      = {{(WIDTH-16){instr[15]}}, instr[15:0]};
    assign imm_zext      = {{(WIDTH-16){1'b0}}, instr[15:0]};
    assign rs_shift      = {{(WIDTH-5){1'b0}}, rs_data[4:0]};
    assign unused_fields = ^instr[25:16];
    assign in_ready      = ~stall;

    logic             dec_legal;
    alu_op_e          dec_sel;
    logic [4:0]       dec_shamt;
    logic [WIDTH-1:0] dec_a;
    logic [WIDTH-1:0] dec_b;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec_legal = 1'b0;
        dec_sel   = OP_ADD;
        dec_shamt = 5'd0;
        dec_a     = rs_data;
        dec_b     = rt_data;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: begin dec_legal = 1'b1; dec_sel = OP_ADD;  end
                    6'h22, 6'h23: begin dec_legal = 1'b1; dec_sel = OP_SUB;  end
                    6'h24:        begin dec_legal = 1'b1; dec_sel = OP_AND;  end
                    6'h25:        begin dec_legal = 1'b1; dec_sel = OP_OR;   end
                    6'h18:        begin dec_legal = 1'b1; dec_sel = OP_MULT; end
                    6'h00, 6'h02: begin
                        dec_legal = 1'b1;
                        dec_sel   = (funct == 6'h00) ? OP_SLL : OP_SRL;
                        dec_a     = rt_data;
                        dec_b     = '0;
                        dec_shamt = instr[10:6];
                    end
                    6'h04, 6'h06, 6'h07: begin
                        dec_legal = 1'b1;
                        dec_sel   = (funct == 6'h04) ? OP_SLLV :
                                    (funct == 6'h06) ? OP_SRLV : OP_SRAV;
                        dec_a     = rt_data;
                        dec_b     = rs_shift;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08, 6'h09, 6'h23, 6'h2B: begin
                dec_legal = 1'b1;
                dec_sel   = OP_ADD;
                dec_b     = imm_sext;
            end
            6'h0C: begin dec_legal = 1'b1; dec_sel = OP_AND; dec_b = imm_zext; end
            6'h0D: begin dec_legal = 1'b1; dec_sel = OP_OR;  dec_b = imm_zext; end
            6'h04, 6'h05: begin dec_legal = 1'b1; dec_sel = OP_SUB; end
            default: dec_legal = 1'b0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            out_valid  <= 1'b0;
            alu_select <= 4'd0;
            alu_shamt  <= 5'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            illegal    <= 1'b0;
        end else if (stall) begin
            illegal    <= 1'b0;
        end else if (in_valid && dec_legal) begin
            out_valid  <= 1'b1;
            alu_select <= dec_sel;
            alu_shamt  <= dec_shamt;
            alu_a      <= dec_a;
            alu_b      <= dec_b;
            illegal    <= 1'b0;
        end else begin
            // Idle cycle or undecodable instruction: load a bubble.
            out_valid  <= 1'b0;
            alu_select <= 4'd0;
            alu_shamt  <= 5'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            illegal    <= in_valid;
        end
    end

`ifdef ILLEGAL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_cnt <= 16'd0;
        end else if (!flush && !stall && in_valid && !dec_legal && illegal_cnt != 16'hFFFF) begin
            illegal_cnt <= illegal_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: stimulus pushes model-predicted register contents,
// a monitor pops and compares them after every clock edge.
module tb_alu_issue_stage;

    typedef struct packed {
        bit        ov;
        bit [3:0]  sel;
        bit [4:0]  shamt;
        bit [31:0] a;
        bit [31:0] b;
        bit        ill;
        bit [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic        flush;
    logic        out_valid;
    logic [3:0]  alu_select;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        illegal;
`ifdef ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif

    alu_issue_stage #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .stall      (stall),
        .flush      (flush),
        .out_valid  (out_valid),
        .alu_select (alu_select),
        .alu_shamt  (alu_shamt),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .illegal    (illegal)
`ifdef ILLEGAL_CNT_EN
        ,
        .illegal_cnt(illegal_cnt)
`endif
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t model;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Specification-level decode: which ALU op an instruction means and what it feeds the ALU.
    function automatic bit ref_decode(input bit [31:0] ins, input bit [31:0] rs, input bit [31:0] rt,
                                      output bit [3:0] sel, output bit [4:0] sh,
                                      output bit [31:0] a, output bit [31:0] b);
        bit [5:0]  op   = ins[31:26];
        bit [5:0]  fn   = ins[5:0];
        int        simm = $signed(ins[15:0]);
        bit [31:0] zimm = 32'(ins[15:0]);
        sel = 4'd0; sh = 5'd0; a = rs; b = rt;
        if (op == 6'h00) begin
            if (fn == 6'h20 || fn == 6'h21) begin sel = 4'd0; return 1; end
            if (fn == 6'h22 || fn == 6'h23) begin sel = 4'd1; return 1; end
            if (fn == 6'h24) begin sel = 4'd5; return 1; end
            if (fn == 6'h25) begin sel = 4'd9; return 1; end
            if (fn == 6'h18) begin sel = 4'd2; return 1; end
            if (fn == 6'h00 || fn == 6'h02) begin
                sel = (fn == 6'h00) ? 4'd3 : 4'd4;
                a = rt; b = 0; sh = ins[10:6];
                return 1;
            end
            if (fn == 6'h04 || fn == 6'h06 || fn == 6'h07) begin
                sel = (fn == 6'h04) ? 4'd8 : (fn == 6'h06) ? 4'd6 : 4'd7;
                a = rt; b = rs % 32;
                return 1;
            end
            return 0;
        end
        if (op == 6'h08 || op == 6'h09 || op == 6'h23 || op == 6'h2B) begin
            b = 32'(simm); return 1;
        end
        if (op == 6'h0C) begin sel = 4'd5; b = zimm; return 1; end
        if (op == 6'h0D) begin sel = 4'd9; b = zimm; return 1; end
        if (op == 6'h04 || op == 6'h05) begin sel = 4'd1; return 1; end
        return 0;
    endfunction

    function automatic exp_t next_state(input exp_t cur, input bit r, input bit v, input bit [31:0] ins,
                                        input bit [31:0] rs, input bit [31:0] rt,
                                        input bit st, input bit fl);
        exp_t      n = cur;
        exp_t      bubble;
        bit [3:0]  sel;
        bit [4:0]  sh;
        bit [31:0] a;
        bit [31:0] b;
        bubble     = '0;
        bubble.cnt = cur.cnt;
        if (r) return '0;
        if (fl) return bubble;
        if (st) begin n.ill = 0; return n; end
        if (!v) return bubble;
        if (ref_decode(ins, rs, rt, sel, sh, a, b)) begin
            n.ov = 1; n.sel = sel; n.shamt = sh; n.a = a; n.b = b; n.ill = 0;
            return n;
        end
        bubble.ill = 1;
        if (cur.cnt != 16'hFFFF) bubble.cnt = cur.cnt + 1;
        return bubble;
    endfunction

    task automatic drive(input bit r, input bit v, input bit [31:0] ins, input bit [31:0] rs,
                         input bit [31:0] rt, input bit st, input bit fl);
        @(negedge clk);
        reset = r; in_valid = v; instr = ins; rs_data = rs; rt_data = rt; stall = st; flush = fl;
        #1;
        check("in_ready", 32'(in_ready), 32'(!st));
        model = next_state(model, r, v, ins, rs, rt, st, fl);
        exp_q.push_back(model);
    endtask

    function automatic bit [31:0] rand_instr();
        bit [5:0] r_ops[6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h18, 6'h00};
        bit [5:0] r_ops2[6] = '{6'h21, 6'h23, 6'h02, 6'h04, 6'h06, 6'h07};
        bit [5:0] i_ops[10] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F, 6'h02};
        bit [31:0] w = $urandom;
        case ($urandom_range(0, 3))
            0: w[31:26] = 6'h00;
            1: begin w[31:26] = 6'h00; w[5:0] = r_ops[$urandom_range(0, 5)]; end
            2: begin w[31:26] = 6'h00; w[5:0] = r_ops2[$urandom_range(0, 5)]; end
            default: w[31:26] = i_ops[$urandom_range(0, 9)];
        endcase
        return w;
    endfunction

    // Monitor: compares the stage contents after every edge that had a prediction queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_valid",  32'(out_valid),  32'(e.ov));
                check("illegal",    32'(illegal),    32'(e.ill));
                check("alu_select", 32'(alu_select), 32'(e.sel));
                check("alu_shamt",  32'(alu_shamt),  32'(e.shamt));
                check("alu_a",      alu_a,           e.a);
                check("alu_b",      alu_b,           e.b);
`ifdef ILLEGAL_CNT_EN
                check("illegal_cnt", 32'(illegal_cnt), 32'(e.cnt));
`endif
            end
        end
    end

    initial begin
        int guard;
        model = '0;
        reset = 1'b1; in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
        stall = 1'b0; flush = 1'b0;

        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h00221820, 3, 4, 0, 0);

        drive(0, 1, 32'h00221820, 5, 7, 0, 0);                      // add
        drive(0, 1, {6'h08, 5'd1, 5'd2, 16'hFFFF}, 10, 3, 0, 0);     // addi -1
        drive(0, 1, {6'h0D, 5'd1, 5'd2, 16'hFFFF}, 10, 3, 0, 0);     // ori
        drive(0, 1, {6'h00, 5'd0, 5'd1, 5'd3, 5'd4, 6'h00}, 9, 1, 0, 0);  // sll 4
        drive(0, 1, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h07}, 32'h25, 32'hFFFF_FFF8, 0, 0); // srav
        drive(0, 1, 32'h0000_0000, 32'h1234, 32'h5678, 0, 0);        // nop
        drive(0, 1, 32'h00221820, 11, 22, 0, 0);
        for (int i = 0; i < 3; i++)
            drive(0, 1, 32'h00221822, 100 + i, 7, 1, 0);               // stall with new instr
        drive(0, 1, 32'h00221822, 100, 7, 0, 0);
        drive(0, 1, 32'h00221825, 1, 2, 1, 1);                       // stall + flush
        drive(0, 1, 32'hFC00_0000, 1, 2, 0, 0);                      // opcode 0x3F
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h00221820, 1, 2, 0, 0);
        drive(0, 1, 32'hFC00_0000, 1, 2, 1, 0);                      // illegal while stalled
        drive(1, 1, 32'h00221820, 1, 2, 1, 1);                       // reset mid stall/flush
        drive(0, 1, 32'h8C22_0010, 32'h1000, 0, 0, 0);               // lw

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rand_instr(),
                  $urandom, $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end

`ifdef ILLEGAL_CNT_EN
        for (int i = 0; i < 70000; i++)
            drive(0, 1, 32'hFC00_0000, 0, 0, 0, 0);
        drive(0, 1, 32'hFC00_0000, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
`endif

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
